coax_buffered_tx_seq: RTL and testbench

Parametrised, buffered word sequencer for the coax transmit path. It collects words into a FIFO and appends a parity bit to each one. It decides when a frame starts: on an explicit strobe, on reaching a fill threshold, or on an idle timeout. It then feeds the words one at a time to the downstream coax word serializer through a ready/strobe handshake, and reports FIFO status, overflow and abort to the host interface.

---
 rtl/coax_buffered_tx_seq.sv | 171 +++++++++++++++++
 tb/tb_coax_buffered_tx_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_buffered_tx_seq.sv
// Buffered coax transmit word sequencer: FIFO + parity + frame start/feed/drain control.
// Optional auto-start (fill threshold / idle timeout) is built when COAX_TX_AUTOSTART_EN is defined.
module coax_buffered_tx_seq #(
    parameter int DATA_WIDTH   = 10,
    parameter int DEPTH        = 16,
    parameter int START_DEPTH  = 8,
    parameter int IDLE_TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH-1:0]      data,
    input  logic                       load_strobe,
    input  logic                       start_strobe,
    input  logic                       abort_strobe,
    input  logic                       parity,
    output logic [DATA_WIDTH:0]        tx_data,
    output logic                       tx_strobe,
    input  logic                       tx_ready,
    input  logic                       tx_active,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       active,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (START_DEPTH < 1) ||
        (START_DEPTH > DEPTH) || (IDLE_TIMEOUT < 2)) begin : g_cfg_err
        $error("coax_buffered_tx_seq: invalid parameter set");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_level;
    logic                    r_tx_strobe;
    logic [DATA_WIDTH:0]     r_tx_data;
    logic                    r_overflow;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_auto_start;
    logic [DATA_WIDTH-1:0]   w_head;
    logic                    w_par_bit;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LVL_FULL);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_par_bit = (^w_head) ^ parity;

    // Pops are spaced by the registered strobe so strobes never land on consecutive cycles.
    assign w_pop  = (r_state == S_SEND) && tx_ready && !w_empty && !r_tx_strobe && !abort_strobe;
    assign w_push = load_strobe && !abort_strobe && (!w_full || w_pop);
    assign w_drop = load_strobe && !abort_strobe && w_full && !w_pop;

`ifdef COAX_TX_AUTOSTART_EN
    localparam int CW = $clog2(IDLE_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(IDLE_TIMEOUT - 1);
    localparam logic [AW:0]   LVL_START = (AW+1)'(START_DEPTH);

    logic [CW-1:0] r_idle_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (load_strobe || (r_state != S_IDLE)) begin
            r_idle_cnt <= '0;
        end else if (!w_empty && (r_idle_cnt != CNT_LAST)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Counter may sit at its limit after a flush; only a non-empty FIFO may trigger a start.
    assign w_auto_start = (r_level >= LVL_START) || (!w_empty && (r_idle_cnt == CNT_LAST));
`else
    assign w_auto_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_tx_strobe <= 1'b0;
            r_tx_data   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_strobe <= w_pop;
            if (w_pop) begin
                r_tx_data <= {w_par_bit, w_head};
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (abort_strobe) begin
                r_rd_ptr   <= r_wr_ptr;
                r_level    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_level <= r_level - 1'b1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort_strobe) begin
            w_state_nxt = tx_active ? S_DRAIN : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((start_strobe && !w_empty) || w_auto_start) begin
                        w_state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_empty && !r_tx_strobe) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_active) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_strobe = r_tx_strobe;
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = r_level;
    assign active    = (r_state != S_IDLE);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_coax_buffered_tx_seq.sv
// Self-checking bench for coax_buffered_tx_seq: queue-based reference model plus directed scenarios.
module tb_coax_buffered_tx_seq;

    localparam int DW           = 10;
    localparam int DEPTH        = 8;
    localparam int START_DEPTH  = 4;
    localparam int IDLE_TIMEOUT = 32;
    localparam int LW           = $clog2(DEPTH) + 1;
    localparam int MI = 0, MS = 1, MD = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data = '0;
    logic          load_strobe = 1'b0;
    logic          start_strobe = 1'b0;
    logic          abort_strobe = 1'b0;
    logic          parity = 1'b0;
    logic [DW:0]   tx_data;
    logic          tx_strobe;
    logic          tx_ready = 1'b1;
    logic          tx_active = 1'b0;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          active;
    logic          overflow;

    coax_buffered_tx_seq #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .START_DEPTH (START_DEPTH),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data        (data),
        .load_strobe (load_strobe),
        .start_strobe(start_strobe),
        .abort_strobe(abort_strobe),
        .parity      (parity),
        .tx_data     (tx_data),
        .tx_strobe   (tx_strobe),
        .tx_ready    (tx_ready),
        .tx_active   (tx_active),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .active      (active),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, the sequencer a small mode variable.
    logic [DW-1:0] m_q[$];
    int            m_mode = MI;
    logic          m_strobe = 1'b0;
    logic [DW:0]   m_txd = '0;
    logic          m_ovf = 1'b0;
    int            m_cnt = 0;

    always @(posedge clk) begin
        int sz;
        int nmode;
        bit pop;
        bit go;
        logic [DW-1:0] w;
        cyc++;
        if (!reset_n) begin
            m_q.delete();
            m_mode = MI; m_strobe = 1'b0; m_txd = '0; m_ovf = 1'b0; m_cnt = 0;
        end else begin
            sz = m_q.size();
            go = 1'b0;
`ifdef COAX_TX_AUTOSTART_EN
            go = (sz >= START_DEPTH) || (sz > 0 && m_cnt == IDLE_TIMEOUT - 1);
`endif
            pop = (m_mode == MS) && tx_ready && (sz > 0) && !m_strobe && !abort_strobe;
            nmode = m_mode;
            if (abort_strobe) nmode = tx_active ? MD : MI;
            else if (m_mode == MI && ((start_strobe && sz > 0) || go)) nmode = MS;
            else if (m_mode == MS && sz == 0 && !m_strobe) nmode = MD;
            else if (m_mode == MD && !tx_active) nmode = MI;
            if (load_strobe || m_mode != MI) m_cnt = 0;
            else if (sz > 0 && m_cnt < IDLE_TIMEOUT - 1) m_cnt++;
            if (pop) begin
                w = m_q.pop_front();
                m_txd = {(^w) ^ parity, w};
            end
            if (abort_strobe) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else if (load_strobe) begin
                if (sz < DEPTH || pop) m_q.push_back(data);
                else m_ovf = 1'b1;
            end
            m_strobe = pop;
            m_mode = nmode;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx_strobe", tx_strobe, m_strobe);
            chk("tx_data", tx_data, m_txd);
            chk("level", level, m_q.size());
            chk("empty", empty, m_q.size() == 0);
            chk("full", full, m_q.size() == DEPTH);
            chk("active", active, m_mode != MI);
            chk("overflow", overflow, m_ovf);
        end
    end

    logic [DW:0] seen[$];
    int          seen_cyc[$];

    always @(negedge clk) begin
        if (tx_strobe === 1'b1) begin
            seen.push_back(tx_data);
            seen_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        data = w; load_strobe = 1'b1;
        tick();
        load_strobe = 1'b0;
    endtask

    task automatic pulse_start();
        start_strobe = 1'b1;
        tick();
        start_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a;
        int c;
        logic [DW-1:0] exp_w[$];
        logic [DW-1:0] w;

        do_reset();
        chk("rst_tx_strobe", tx_strobe, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_active", active, 0);

        // Explicit start with odd parity.
        parity = 1'b1; tx_active = 1'b1;
        load(10'h175); load(10'h28E); load(10'h175);
        seen.delete(); seen_cyc.delete();
        pulse_start_at(a);
        chk("t1_active_n1", active, 1);
        repeat (8) tick();
        tx_active = 1'b0;
        repeat (3) tick();
        chk("t1_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("t1_w0", seen[0], 11'h575);
            chk("t1_w1", seen[1], 11'h28E);
            chk("t1_w2", seen[2], 11'h575);
            chk("t1_first_lat", seen_cyc[0] - a, 2);
            chk("t1_gap", seen_cyc[1] - seen_cyc[0], 2);
        end
        chk("t1_empty", empty, 1);
        chk("t1_idle", active, 0);

        // Threshold start (auto build) or explicit start (default build), even parity.
        do_reset();
        parity = 1'b0; tx_active = 1'b1;
        seen.delete(); seen_cyc.delete();
        load(10'h001); load(10'h002); load(10'h003); load(10'h004);
`ifdef COAX_TX_AUTOSTART_EN
        chk("t2_auto_active", active, 1);
`else
        repeat (5) tick();
        chk("t2_no_auto", active, 0);
        pulse_start();
`endif
        repeat (10) tick();
        tx_active = 1'b0;
        repeat (3) tick();
        chk("t2_count", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("t2_w0", seen[0], 11'h401);
            chk("t2_w1", seen[1], 11'h402);
            chk("t2_w2", seen[2], 11'h003);
            chk("t2_w3", seen[3], 11'h404);
        end

        // Idle timeout.
        do_reset();
        seen.delete(); seen_cyc.delete();
        c = cyc;
        load(10'h155);
`ifdef COAX_TX_AUTOSTART_EN
        for (int i = 0; i < 60 && seen.size() == 0; i++) tick();
        chk("t3_seen", seen.size() > 0, 1);
        if (seen.size() > 0) chk("t3_lat", seen_cyc[0] - c, 34);
        tx_active = 1'b0;
        repeat (4) tick();
        seen.delete(); seen_cyc.delete();
        c = cyc;
        load(10'h0AA);
        repeat (19) tick();
        load(10'h0AB);
        for (int i = 0; i < 80 && seen.size() == 0; i++) tick();
        chk("t3_restart_seen", seen.size() > 0, 1);
        if (seen.size() > 0) chk("t3_restart_lat", seen_cyc[0] - c, 54);
        repeat (6) tick();
`else
        repeat (60) tick();
        chk("t3_no_timeout", active, 0);
        chk("t3_level", level, 1);
`endif

`ifndef COAX_TX_AUTOSTART_EN
        // Overflow and pointer wrap over three rounds.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            exp_w.delete(); seen.delete(); seen_cyc.delete();
            for (int i = 0; i < 9; i++) begin
                w = 10'(r * 40 + i * 3 + 1);
                load(w);
                if (i < 8) exp_w.push_back(w);
            end
            chk("t4_level", level, 8);
            chk("t4_full", full, 1);
            chk("t4_ovf", overflow, 1);
            tx_active = 1'b1;
            pulse_start();
            if (r == 2) begin
                load(10'h3AA);
                exp_w.push_back(10'h3AA);
                chk("t4_full_loadpop", level, 8);
            end
            repeat (24) tick();
            tx_active = 1'b0;
            repeat (3) tick();
            chk("t4_count", seen.size(), exp_w.size());
            if (seen.size() == exp_w.size()) begin
                for (int i = 0; i < exp_w.size(); i++) chk("t4_order", seen[i][DW-1:0], exp_w[i]);
            end
            chk("t4_empty", empty, 1);
        end
`endif

        // Abort mid-frame with toggling tx_ready and a same-cycle load.
        do_reset();
        tx_active = 1'b1;
        for (int i = 0; i < 6; i++) load(10'(10'h100 + i));
        seen.delete(); seen_cyc.delete();
        pulse_start();
        for (int i = 0; i < 50 && seen.size() < 2; i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        chk("t5_two_strobes", seen.size(), 2);
        abort_strobe = 1'b1; load_strobe = 1'b1; data = 10'h3FF;
        tick();
        abort_strobe = 1'b0; load_strobe = 1'b0; tx_ready = 1'b1;
        chk("t5_level", level, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_drain", active, 1);
        repeat (6) tick();
        chk("t5_no_more", seen.size(), 2);
        chk("t5_still_drain", active, 1);
        tx_active = 1'b0;
        tick();
        chk("t5_idle", active, 0);

        // Reset during SEND.
        tx_active = 1'b1;
        for (int i = 0; i < 5; i++) load(10'(10'h040 + i));
        pulse_start();
        repeat (3) tick();
        chk("t6_in_send", active, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_strobe", tx_strobe, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_empty", empty, 1);
        chk("t6_full", full, 0);
        chk("t6_level", level, 0);
        chk("t6_active", active, 0);
        chk("t6_ovf", overflow, 0);
        seen.delete();
        repeat (10) tick();
        chk("t6_lost", seen.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic pulse_start_at(output int at);
        at = cyc;
        pulse_start();
    endtask

endmodule
